ov_sccb_responder: RTL and testbench

Camera-side (responder) end of the Omnivision SCCB link. It decodes 3-phase write, 2-phase write and 2-phase read transactions from an SCCB initiator, and maps them onto a simple synchronous register-file port.

- Used as the camera model in system benches.
- Used as the SCCB target in the on-board camera emulator.
- All bus inputs are oversampled on the system clock; no logic runs on `sio_c` as a clock.

---
 rtl/ov_sccb_responder.sv | 187 ++++++++++++++++++
 tb/tb_ov_sccb_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov_sccb_responder.sv
// SCCB responder: decodes 3-phase write, 2-phase write and 2-phase read
// cycles from an oversampled SCCB bus onto a simple register-file port.
`timescale 1ns/1ps

module ov_sccb_responder #(
    parameter logic [7:0] DEV_ADDR    = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sio_c,
    inout  wire        sio_d,
    input  logic       sccb_e,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_SUBADDR,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] c_sync;
    logic [SYNC_STAGES-1:0] d_sync;
    logic [SYNC_STAGES-1:0] e_sync;
    logic                   c_q;
    logic                   d_q;

    logic [3:0] bit_cnt;
    logic [6:0] sh;
    logic [7:0] tx;
    logic       rd;
    logic       ld;
    logic       oe;
    logic       dout;

    logic       c_s;
    logic       d_s;
    logic       e_s;
    logic       c_rise;
    logic       c_fall;
    logic       start;
    logic       stop;
    logic [7:0] byte_in;

    assign sio_d = oe ? dout : 1'bz;

    // Synchronizers idle high so reset never fabricates an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync <= '1;
            d_sync <= '1;
            e_sync <= '1;
            c_q    <= 1'b1;
            d_q    <= 1'b1;
        end else begin
            c_sync[0] <= sio_c;
            d_sync[0] <= sio_d;
            e_sync[0] <= sccb_e;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                c_sync[i] <= c_sync[i-1];
                d_sync[i] <= d_sync[i-1];
                e_sync[i] <= e_sync[i-1];
            end
            c_q <= c_sync[SYNC_STAGES-1];
            d_q <= d_sync[SYNC_STAGES-1];
        end
    end

    assign c_s     = c_sync[SYNC_STAGES-1];
    assign d_s     = d_sync[SYNC_STAGES-1];
    assign e_s     = e_sync[SYNC_STAGES-1];
    assign c_rise  = c_s & ~c_q;
    assign c_fall  = ~c_s & c_q;
    assign start   = ~e_s & c_s & c_q & ~d_s & d_q;
    assign stop    = ~e_s & c_s & c_q & d_s & ~d_q;
    assign byte_in = {sh, d_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            sh        <= 7'd0;
            tx        <= 8'd0;
            rd        <= 1'b0;
            ld        <= 1'b0;
            oe        <= 1'b0;
            dout      <= 1'b0;
            reg_addr  <= 8'd0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            ld     <= reg_re;
            if (ld) begin
                tx <= reg_rdata;
            end

            if (e_s) begin
                state   <= S_IDLE;
                bit_cnt <= 4'd0;
                oe      <= 1'b0;
                busy    <= 1'b0;
            end else if (start) begin
                state   <= S_ADDR;
                bit_cnt <= 4'd0;
                oe      <= 1'b0;
                busy    <= 1'b1;
            end else if (stop) begin
                state   <= S_IDLE;
                bit_cnt <= 4'd0;
                oe      <= 1'b0;
                busy    <= 1'b0;
            end else begin
                unique case (state)
                    S_ADDR, S_SUBADDR, S_WDATA: begin
                        if (c_rise && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            unique case (state)
                                S_ADDR:    state <= rd ? S_RDATA : S_SUBADDR;
                                S_SUBADDR: state <= S_WDATA;
                                default:   state <= S_IGNORE;
                            endcase
                        end else if (c_rise) begin
                            sh      <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                unique case (state)
                                    S_ADDR: begin
                                        if (byte_in[7:1] != DEV_ADDR[7:1]) begin
                                            state <= S_IGNORE;
                                        end else begin
                                            rd     <= byte_in[0];
                                            reg_re <= byte_in[0];
                                        end
                                    end
                                    S_SUBADDR: reg_addr <= byte_in;
                                    default: begin
                                        reg_wdata <= byte_in;
                                        reg_we    <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    S_RDATA: begin
                        // Data changes only while sio_c is low
                        if (c_fall) begin
                            if (bit_cnt < 4'd8) begin
                                oe   <= 1'b1;
                                dout <= tx[7];
                                tx   <= {tx[6:0], 1'b0};
                            end else begin
                                oe <= 1'b0;
                            end
                        end
                        if (c_rise) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                oe      <= 1'b0;
                                state   <= S_IGNORE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_IDLE, S_IGNORE: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov_sccb_responder.sv
// Directed bench for ov_sccb_responder: an SCCB initiator model on a
// pulled-up sio_d line plus a small register-file model.
`timescale 1ns/1ps

module tb_ov_sccb_responder;

    localparam int H = 80;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       sio_c  = 1'b1;
    logic       sccb_e = 1'b1;
    logic       m_oe   = 1'b0;
    logic       m_d    = 1'b1;
    wire        sio_d;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    logic [7:0] mem [0:255];
    int         we_cnt  = 0;
    int         re_cnt  = 0;
    logic [7:0] re_addr = 8'd0;
    int         n_chk   = 0;
    int         n_fail  = 0;

    assign sio_d = m_oe ? m_d : 1'bz;
    pullup (sio_d);
    assign reg_rdata = mem[reg_addr];

    ov_sccb_responder #(
        .DEV_ADDR    (8'h42),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sio_c     (sio_c),
        .sio_d     (sio_d),
        .sccb_e    (sccb_e),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_we) we_cnt++;
        if (reg_re) begin
            re_cnt++;
            re_addr = reg_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        m_oe   = 1'b1;
        m_d    = 1'b1;
        sio_c  = 1'b1;
        sccb_e = 1'b1;
        #(H);
    endtask

    task automatic start_c();
        sccb_e = 1'b0;
        m_oe   = 1'b1;
        m_d    = 1'b1;
        #(H/2);
        sio_c = 1'b1;
        #(H);
        m_d = 1'b0;
        #(H);
        sio_c = 1'b0;
    endtask

    task automatic wbit(input logic b);
        m_oe = 1'b1;
        #(H/2);
        m_d = b;
        #(H/2);
        sio_c = 1'b1;
        #(H);
        sio_c = 1'b0;
    endtask

    task automatic rbit(output logic b);
        m_oe = 1'b0;
        #(H);
        b = sio_d;
        sio_c = 1'b1;
        #(H);
        sio_c = 1'b0;
    endtask

    task automatic wbyte(input logic [7:0] v, output logic nb);
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(nb);
    endtask

    task automatic rbyte(output logic [7:0] v, output logic na);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            v[i] = b;
        end
        rbit(na);
    endtask

    task automatic stop_bus(input logic drop_e);
        m_oe = 1'b1;
        #(H/2);
        m_d = 1'b0;
        #(H/2);
        sio_c = 1'b1;
        #(H);
        m_d = 1'b1;
        #(H);
        if (drop_e) sccb_e = 1'b1;
        #(H);
    endtask

    initial begin
        int         we0;
        int         re0;
        logic       nb;
        logic       na;
        logic       b;
        logic [7:0] v;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'hA5;
        mem[8'h0A] = 8'h76;
        mem[8'h33] = 8'h81;

        #23;
        reset = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_we", reg_we, 0);
        check("rst_re", reg_re, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_sio_d", sio_d, 1);
        bus_idle();

        // 1: 3-phase write 0x42/0x12/0x80
        we0 = we_cnt;
        re0 = re_cnt;
        start_c();
        #1 check("t1_busy_start", busy, 1);
        wbyte(8'h42, nb);
        check("t1_bit9_a", nb, 1);
        wbyte(8'h12, nb);
        check("t1_bit9_s", nb, 1);
        wbyte(8'h80, nb);
        check("t1_bit9_d", nb, 1);
        stop_bus(1'b1);
        check("t1_we_cnt", we_cnt - we0, 1);
        check("t1_re_cnt", re_cnt - re0, 0);
        check("t1_addr", reg_addr, 8'h12);
        check("t1_wdata", reg_wdata, 8'h80);
        check("t1_busy_end", busy, 0);

        // 2: set sub-address 0x0A, then read it back
        we0 = we_cnt;
        re0 = re_cnt;
        start_c();
        wbyte(8'h42, nb);
        wbyte(8'h0A, nb);
        stop_bus(1'b1);
        check("t2_addr", reg_addr, 8'h0A);
        start_c();
        wbyte(8'h43, nb);
        check("t2_bit9_a", nb, 1);
        rbyte(v, na);
        check("t2_rdata", v, 8'h76);
        check("t2_na_released", na, 1);
        stop_bus(1'b1);
        check("t2_re_cnt", re_cnt - re0, 1);
        check("t2_re_addr", re_addr, 8'h0A);
        check("t2_we_cnt", we_cnt - we0, 0);

        // 3: foreign device address, full write ignored
        we0 = we_cnt;
        re0 = re_cnt;
        start_c();
        wbyte(8'h60, nb);
        wbyte(8'h12, nb);
        wbyte(8'h34, nb);
        check("t3_bit9", nb, 1);
        check("t3_busy_mid", busy, 1);
        stop_bus(1'b1);
        check("t3_busy_end", busy, 0);
        check("t3_we_cnt", we_cnt - we0, 0);
        check("t3_re_cnt", re_cnt - re0, 0);
        check("t3_addr", reg_addr, 8'h0A);

        // 4: abort via sccb_e after 4 data bits
        we0 = we_cnt;
        start_c();
        wbyte(8'h42, nb);
        wbyte(8'h05, nb);
        for (int i = 0; i < 4; i++) wbit(1'b1);
        check("t4_busy_pre", busy, 1);
        #(H/4);
        sccb_e = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t4_busy_abort", busy, 0);
        bus_idle();
        bus_idle();
        check("t4_we_cnt", we_cnt - we0, 0);
        check("t4_addr", reg_addr, 8'h05);

        // 5: partial sub-address after reset, then read register 0
        reset = 1'b1;
        #20;
        reset = 1'b0;
        bus_idle();
        we0 = we_cnt;
        re0 = re_cnt;
        start_c();
        wbyte(8'h42, nb);
        for (int i = 0; i < 5; i++) wbit(i[0]);
        stop_bus(1'b0);
        check("t5_addr_kept", reg_addr, 8'h00);
        start_c();
        wbyte(8'h43, nb);
        rbyte(v, na);
        stop_bus(1'b1);
        check("t5_rdata", v, 8'hA5);
        check("t5_re_addr", re_addr, 8'h00);
        check("t5_re_cnt", re_cnt - re0, 1);
        check("t5_we_cnt", we_cnt - we0, 0);

        // 6: reset while read bit 3 (a zero) is on the bus
        start_c();
        wbyte(8'h42, nb);
        wbyte(8'h33, nb);
        stop_bus(1'b1);
        start_c();
        wbyte(8'h43, nb);
        for (int i = 0; i < 3; i++) rbit(b);
        m_oe = 1'b0;
        #(H*3/4);
        check("t6_driven_low", sio_d, 0);
        reset = 1'b1;
        #1;
        check("t6_released", sio_d, 1);
        check("t6_busy", busy, 0);
        check("t6_re", reg_re, 0);
        check("t6_we", reg_we, 0);
        check("t6_addr", reg_addr, 8'h00);
        sio_c  = 1'b1;
        sccb_e = 1'b1;
        m_oe   = 1'b1;
        m_d    = 1'b1;
        #20;
        reset = 1'b0;
        bus_idle();
        we0 = we_cnt;
        start_c();
        wbyte(8'h42, nb);
        wbyte(8'h21, nb);
        wbyte(8'h5A, nb);
        stop_bus(1'b1);
        check("t6_we_cnt", we_cnt - we0, 1);
        check("t6_post_addr", reg_addr, 8'h21);
        check("t6_post_wdata", reg_wdata, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
